// File: rtl/nnrv_ram_arb.sv
// Single-port RAM arbiter shared by the nnrv IF (read-only) and MEM (load/store) requesters.
// MEM has priority; a bounded streak counter forces IF through after MAX_STREAK contended MEM grants.
//
// rd_owner  | meaning
// ----------+----------------------------------------------------
// OWN_NONE  | no read outstanding, no rvalid this cycle
// OWN_IF    | IF read granted last cycle, RAM data returns to IF
// OWN_MEM   | MEM read granted last cycle, RAM data returns to MEM
module nnrv_ram_arb #(
    parameter int XLEN         = 64,
    parameter int ADDR_WIDTH   = 8,
    parameter int MASK_WIDTH   = 8,
    parameter int MAX_STREAK   = 3,
    parameter int STREAK_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [XLEN-1:0]       i_if_addr,
    input  logic [MASK_WIDTH-1:0] i_if_mask,
    input  logic                  i_if_flush,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [XLEN-1:0]       o_if_rdata,
    input  logic                  i_mem_req,
    input  logic                  i_mem_we,
    input  logic [XLEN-1:0]       i_mem_addr,
    input  logic [MASK_WIDTH-1:0] i_mem_mask,
    input  logic [XLEN-1:0]       i_mem_wdata,
    output logic                  o_mem_gnt,
    output logic                  o_mem_rvalid,
    output logic [XLEN-1:0]       o_mem_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [MASK_WIDTH-1:0] o_ram_mask,
    output logic [XLEN-1:0]       o_ram_wdata,
    input  logic [XLEN-1:0]       i_ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

    owner_t                  rd_owner;
    owner_t                  rd_owner_nxt;
    logic [STREAK_WIDTH-1:0] streak;
    logic [STREAK_WIDTH-1:0] streak_nxt;
    logic                    streak_full;
    logic                    if_ok;
    logic                    mem_win;
    logic                    if_win;

    // Upper address bits wrap away; keep them visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_if_addr[XLEN-1:ADDR_WIDTH], i_mem_addr[XLEN-1:ADDR_WIDTH]};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_owner <= OWN_NONE;
            streak   <= '0;
        end else begin
            rd_owner <= rd_owner_nxt;
            streak   <= streak_nxt;
        end
    end

    // Qualifying with i_rst keeps every combinational output at 0 while reset is held.
    always_comb begin
        streak_full = (streak == STREAK_WIDTH'(MAX_STREAK));
        if_ok       = i_rst & i_if_req & ~i_if_flush;
        mem_win     = i_rst & i_mem_req & ~(if_ok & streak_full);
        if_win      = if_ok & ~mem_win;

        rd_owner_nxt = OWN_NONE;
        if (if_win) begin
            rd_owner_nxt = OWN_IF;
        end else if (mem_win && !i_mem_we) begin
            rd_owner_nxt = OWN_MEM;
        end

        streak_nxt = '0;
        if (mem_win && if_ok) begin
            streak_nxt = streak_full ? streak : streak + 1'b1;
        end
    end

    always_comb begin
        o_mem_gnt   = mem_win;
        o_if_gnt    = if_win;
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_mask  = '0;
        o_ram_wdata = '0;
        if (mem_win) begin
            o_ram_en    = 1'b1;
            o_ram_we    = i_mem_we;
            o_ram_addr  = i_mem_addr[ADDR_WIDTH-1:0];
            o_ram_mask  = i_mem_mask;
            o_ram_wdata = i_mem_wdata;
        end else if (if_win) begin
            o_ram_en   = 1'b1;
            o_ram_addr = i_if_addr[ADDR_WIDTH-1:0];
            o_ram_mask = i_if_mask;
        end
    end

    // A flush in the return cycle drops IF data even though the read already happened.
    always_comb begin
        o_if_rvalid  = (rd_owner == OWN_IF) & ~i_if_flush;
        o_mem_rvalid = (rd_owner == OWN_MEM);
        o_if_rdata   = o_if_rvalid ? i_ram_rdata : '0;
        o_mem_rdata  = o_mem_rvalid ? i_ram_rdata : '0;
    end

endmodule

// File: tb/tb_nnrv_ram_arb.sv
// Directed bench for nnrv_ram_arb with a byte-masked synchronous RAM model behind the port.
module tb_nnrv_ram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_req, mem_we;
    logic [63:0] if_addr, mem_addr, mem_wdata;
    logic [7:0]  if_mask, mem_mask;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
    logic [63:0] if_rdata, mem_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr, ram_mask;
    logic [63:0] ram_wdata, ram_rdata;
    logic [63:0] ram [0:255];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    nnrv_ram_arb dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .i_if_mask    (if_mask),
        .i_if_flush   (if_flush),
        .o_if_gnt     (if_gnt),
        .o_if_rvalid  (if_rvalid),
        .o_if_rdata   (if_rdata),
        .i_mem_req    (mem_req),
        .i_mem_we     (mem_we),
        .i_mem_addr   (mem_addr),
        .i_mem_mask   (mem_mask),
        .i_mem_wdata  (mem_wdata),
        .o_mem_gnt    (mem_gnt),
        .o_mem_rvalid (mem_rvalid),
        .o_mem_rdata  (mem_rdata),
        .o_ram_en     (ram_en),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_mask   (ram_mask),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    // RAM contents are preloaded whenever reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            ram[8'h10] <= 64'hDEAD;
            ram[8'h28] <= 64'h0;
            ram[8'h30] <= 64'h1F1F;
            ram[8'h40] <= 64'h4E4E;
            ram[8'h04] <= 64'h0;
            ram_rdata  <= 64'h0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_mask[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    task automatic idle();
        if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; if_mask = 0; mem_mask = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        if_req = 1; if_addr = 64'h10; if_mask = 8'hFF;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt got %b want 0", if_gnt); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        checks++; if (ram_addr !== 8'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 00", ram_addr); end
        checks++; if ({if_rvalid, mem_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {if_rvalid, mem_rvalid}); end
        checks++; if ((if_rdata | mem_rdata) !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", if_rdata | mem_rdata); end
        idle();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req = 1; if_addr = 64'h10; if_mask = 8'hFF;
        #1;
        checks++; if ({if_gnt, mem_gnt} !== 2'b10) begin errors++; $display("FAIL if_read_gnt got %b want 10", {if_gnt, mem_gnt}); end
        checks++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h10}) begin errors++; $display("FAIL if_read_ram got en=%b we=%b addr=%h want 1 0 10", ram_en, ram_we, ram_addr); end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({if_rvalid, mem_rvalid} !== 2'b10) begin errors++; $display("FAIL if_read_rvalid got %b want 10", {if_rvalid, mem_rvalid}); end
        checks++; if (if_rdata !== 64'hDEAD) begin errors++; $display("FAIL if_read_rdata got %h want dead", if_rdata); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL if_read_idle_en got %b want 0", ram_en); end
    endtask

    task automatic test_mem_write();
        @(negedge clk);
        mem_req = 1; mem_we = 1; mem_addr = 64'h28; mem_wdata = 64'h1234; mem_mask = 8'hFF;
        #1;
        checks++; if ({mem_gnt, if_gnt, ram_we} !== 3'b101) begin errors++; $display("FAIL wr_gnt got mgnt=%b igNt=%b we=%b want 1 0 1", mem_gnt, if_gnt, ram_we); end
        checks++; if ({ram_addr, ram_wdata, ram_mask} !== {8'h28, 64'h1234, 8'hFF}) begin errors++; $display("FAIL wr_ram got addr=%h wdata=%h mask=%h want 28 1234 ff", ram_addr, ram_wdata, ram_mask); end
        @(negedge clk);
        mem_wdata = 64'hAAAA_BBBB_CCCC_DDDD; mem_mask = 8'h0F;
        #1;
        checks++; if ({mem_rvalid, if_rvalid} !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid got %b want 00", {mem_rvalid, if_rvalid}); end
        checks++; if (ram_mask !== 8'h0F) begin errors++; $display("FAIL wr_mask got %h want 0f", ram_mask); end
        @(negedge clk);
        mem_we = 0; mem_wdata = 64'h5555; mem_mask = 8'hFF;
        #1;
        checks++; if ({mem_gnt, ram_we, ram_wdata} !== {1'b1, 1'b0, 64'h5555}) begin errors++; $display("FAIL rd_ram got gnt=%b we=%b wdata=%h want 1 0 5555", mem_gnt, ram_we, ram_wdata); end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({mem_rvalid, if_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_rvalid got %b want 10", {mem_rvalid, if_rvalid}); end
        checks++; if (mem_rdata !== 64'h0000_0000_CCCC_DDDD) begin errors++; $display("FAIL rd_rdata got %h want 00000000ccccdddd", mem_rdata); end
        checks++; if (if_rdata !== 64'h0) begin errors++; $display("FAIL rd_if_rdata got %h want 0", if_rdata); end
    endtask

    task automatic test_contention();
        logic prev_mem;
        logic exp_mem;
        prev_mem = 0;
        @(negedge clk);
        if_req = 1; if_addr = 64'h30; if_mask = 8'hFF;
        mem_req = 1; mem_we = 0; mem_addr = 64'h40; mem_mask = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            #1;
            exp_mem = ((i % 4) != 3);
            checks++; if ({mem_gnt, if_gnt} !== {exp_mem, ~exp_mem}) begin errors++; $display("FAIL cont_gnt[%0d] got m=%b i=%b want m=%b", i, mem_gnt, if_gnt, exp_mem); end
            if (i > 0) begin
                checks++;
                if (prev_mem ? ({mem_rvalid, if_rvalid, mem_rdata} !== {2'b10, 64'h4E4E})
                             : ({mem_rvalid, if_rvalid, if_rdata} !== {2'b01, 64'h1F1F})) begin
                    errors++; $display("FAIL cont_ret[%0d] got mv=%b iv=%b md=%h id=%h want owner_mem=%b", i, mem_rvalid, if_rvalid, mem_rdata, if_rdata, prev_mem);
                end
            end
            prev_mem = exp_mem;
            @(negedge clk);
        end
        idle();
        #1;
        checks++; if ({mem_rvalid, if_rvalid, mem_rdata} !== {2'b10, 64'h4E4E}) begin errors++; $display("FAIL cont_last got mv=%b iv=%b md=%h want 1 0 4e4e", mem_rvalid, if_rvalid, mem_rdata); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        if_req = 1; if_addr = 64'h10; if_mask = 8'hFF;
        #1;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_pre_gnt got %b want 1", if_gnt); end
        @(negedge clk);
        if_flush = 1; mem_req = 1; mem_we = 0; mem_addr = 64'h40; mem_mask = 8'hFF;
        #1;
        checks++; if ({if_gnt, mem_gnt} !== 2'b01) begin errors++; $display("FAIL flush_gnt got i=%b m=%b want 0 1", if_gnt, mem_gnt); end
        checks++; if ({if_rvalid, if_rdata} !== {1'b0, 64'h0}) begin errors++; $display("FAIL flush_rvalid got v=%b d=%h want 0 0", if_rvalid, if_rdata); end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({mem_rvalid, if_rvalid, mem_rdata} !== {2'b10, 64'h4E4E}) begin errors++; $display("FAIL flush_mem_ret got mv=%b iv=%b md=%h want 1 0 4e4e", mem_rvalid, if_rvalid, mem_rdata); end
    endtask

    task automatic test_reset_mid_read();
        logic exp_mem;
        @(negedge clk);
        if_req = 1; if_addr = 64'h30; if_mask = 8'hFF;
        mem_req = 1; mem_we = 0; mem_addr = 64'h40; mem_mask = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        checks++; if ({mem_gnt, if_gnt, ram_en, mem_rvalid, if_rvalid} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctl got mg=%b ig=%b en=%b mv=%b iv=%b want all 0", mem_gnt, if_gnt, ram_en, mem_rvalid, if_rvalid); end
        checks++; if ({mem_rdata, ram_addr, ram_mask} !== 80'h0) begin errors++; $display("FAIL rst_mid_data got md=%h a=%h m=%h want 0", mem_rdata, ram_addr, ram_mask); end
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rvalid got %b want 0", mem_rvalid); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #1;
            exp_mem = (i != 3);
            checks++; if ({mem_gnt, if_gnt} !== {exp_mem, ~exp_mem}) begin errors++; $display("FAIL rst_streak[%0d] got m=%b i=%b want m=%b", i, mem_gnt, if_gnt, exp_mem); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        if_req = 1; if_addr = 64'h1_0000_0104; if_mask = 8'h0F;
        #1;
        checks++; if ({if_gnt, ram_addr, ram_mask} !== {1'b1, 8'h04, 8'h0F}) begin errors++; $display("FAIL wrap got gnt=%b addr=%h mask=%h want 1 04 0f", if_gnt, ram_addr, ram_mask); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write();
        test_contention();
        test_flush();
        test_reset_mid_read();
        test_addr_wrap();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
